// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: blank pattern, active-low hex encoding table and lookup helper.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

  // Segments {g,f,e,d,c,b,a}, active-low; entry n is the glyph for hex digit n.
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [SEG_W-1:0] hex2seg(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low 7-segment pattern.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0]       nibble_i,
  output logic [SEG_W-1:0] seg_c
);

  assign seg_c = hex2seg(nibble_i);

endmodule

// File: rtl/mmio_hex_display.sv
// Memory-mapped multiplexed hex display: captures CPU stores to DISP_ADDR and scans them out.
// Optional leading-zero blanking is enabled by defining HEX_LZ_BLANK_EN.
module mmio_hex_display
  import seg7_pkg::*;
#(
  parameter int unsigned        NUM_DIGITS  = 4,
  parameter int unsigned        DATA_W      = 32,
  parameter logic [DATA_W-1:0]  DISP_ADDR   = DATA_W'(32'h0000_0100),
  parameter int unsigned        REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_write,
  input  logic [DATA_W-1:0]       adr,
  input  logic [DATA_W-1:0]       write_data,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [SEG_W-1:0]        catode,
  output logic [4*NUM_DIGITS-1:0] shown
);

  localparam int unsigned VAL_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [VAL_W-1:0]      value_q, value_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [SEG_W-1:0]      catode_q, catode_d;
  logic [3:0]            nibble_c;
  logic [SEG_W-1:0]      seg_c;
  logic                  blank_c;
`ifdef HEX_LZ_BLANK_EN
  logic                  upper_zero_c;
`endif

  // Capture register: only stores addressed to the display update it.
  always_comb begin
    value_d = value_q;
    if (mem_write && (adr == DISP_ADDR)) begin
      value_d = write_data[VAL_W-1:0];
    end
  end

  // Refresh slot timer and digit index.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Digit select, nibble mux and blanking decision for the current index.
  always_comb begin
    anode_d  = '1;
    nibble_c = '0;
    blank_c  = 1'b0;
`ifdef HEX_LZ_BLANK_EN
    upper_zero_c = 1'b1;
`endif
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
`ifdef HEX_LZ_BLANK_EN
      upper_zero_c = upper_zero_c & (value_q[4*i +: 4] == 4'h0);
`endif
      if (IDX_W'(i) == idx_q) begin
        anode_d[i] = 1'b0;
        nibble_c   = value_q[4*i +: 4];
`ifdef HEX_LZ_BLANK_EN
        blank_c    = (i != 0) && upper_zero_c;
`else
        blank_c    = 1'b0;
`endif
      end
    end
    catode_d = blank_c ? SEG_OFF : seg_c;
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nibble_i (nibble_c),
    .seg_c    (seg_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q  <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      anode_q  <= '1;
      catode_q <= SEG_OFF;
    end else begin
      value_q  <= value_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      anode_q  <= anode_d;
      catode_q <= catode_d;
    end
  end

  // Store data bits above the displayed width are intentionally ignored.
  if (VAL_W < DATA_W) begin : g_wdata_unused
    logic unused_wdata_c;
    assign unused_wdata_c = ^write_data[DATA_W-1:VAL_W];
  end

  assign anode  = anode_q;
  assign catode = catode_q;
  assign shown  = value_q;

endmodule
